// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x oversampled 8N1 serial receiver with start/stop validation
// and a single-entry valid/ready holding register.
module uart_rx_core #(
  parameter int DATA_BITS   = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_enable,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);
  localparam int BW = $clog2(DATA_BITS + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxd, rxd_q, fall, tick, mid, last, stop_smp, deliver;
  logic [DIV_WIDTH-1:0]   cnt;
  logic [3:0]             scnt;
  logic [BW-1:0]          bcnt;
  logic [DATA_BITS-1:0]   shreg;
  assign rxd      = sync[SYNC_STAGES-1];
  assign fall     = rxd_q & ~rxd;
  assign mid      = tick & (scnt == 4'd7);
  assign last     = tick & (scnt == 4'd15);
  assign stop_smp = (state == STOP) & last & rx_enable;
  assign deliver  = stop_smp & rxd;
  assign busy     = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = fall ? START : IDLE;
      START: state_n = mid ? (rxd ? IDLE : DATA) : START;
      DATA:  state_n = (last && bcnt == BW'(DATA_BITS - 1)) ? STOP : DATA;
      STOP:  state_n = last ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
    if (!rx_enable) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // Tick phase is anchored to START entry: counters are held clear while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '1;
      rxd_q <= 1'b1;
      cnt   <= '0;
      tick  <= 1'b0;
      scnt  <= '0;
      bcnt  <= '0;
      shreg <= '0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], uart_rxd};
      rxd_q <= rxd;
      if (state == IDLE) begin
        cnt  <= '0;
        tick <= 1'b0;
        scnt <= '0;
      end else begin
        tick <= cnt == baud_div;
        cnt  <= (cnt == baud_div) ? '0 : cnt + 1'b1;
        if (tick) scnt <= (state == START && mid) ? 4'd0 : scnt + 4'd1;
      end
      if (state == START) bcnt <= '0;
      else if (state == DATA && last) bcnt <= bcnt + 1'b1;
      if (state == DATA && last) shreg <= {rxd, shreg[DATA_BITS-1:1]};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= stop_smp & ~rxd;
      overrun_err <= deliver & rx_valid & ~rx_ready;
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed scenarios for the UART receive core at 80 clocks per bit.
module tb_uart_rx_core;
  localparam int BIT = 80;
  logic        clk = 1'b0;
  logic        rst_n, rx_enable, uart_rxd, rx_ready;
  logic [15:0] baud_div;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_err, overrun_err, busy;
  int n_cmp = 0, n_mis = 0;
  int cyc = 0, t_busy_rise, t_busy_fall, t_valid_rise;
  int n_fe, n_oe, n_acc, n_vcyc, n_brise;
  logic [7:0] last_acc;
  logic busy_d = 1'b0, valid_d = 1'b0;

  uart_rx_core dut (
    .clk(clk), .rst_n(rst_n), .rx_enable(rx_enable), .baud_div(baud_div),
    .uart_rxd(uart_rxd), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun_err(overrun_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (busy && !busy_d) begin t_busy_rise = cyc; n_brise++; end
    if (!busy && busy_d) t_busy_fall = cyc;
    if (rx_valid && !valid_d) t_valid_rise = cyc;
    if (frame_err) n_fe++;
    if (overrun_err) n_oe++;
    if (rx_valid) n_vcyc++;
    if (rx_valid && rx_ready) begin n_acc++; last_acc = rx_data; end
    busy_d = busy;
    valid_d = rx_valid;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    n_fe = 0; n_oe = 0; n_acc = 0; n_vcyc = 0; n_brise = 0;
    t_busy_rise = -1; t_busy_fall = -1; t_valid_rise = -1; last_acc = 8'hxx;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    uart_rxd = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      wait_clks(BIT);
    end
    uart_rxd = stop;
    wait_clks(BIT);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_enable = 1'b1; uart_rxd = 1'b1; rx_ready = 1'b1; baud_div = 16'd4;
    #23;
    n_cmp++; if (rx_data !== 8'h00) begin n_mis++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    n_cmp++; if ({rx_valid, frame_err, overrun_err, busy} !== 4'b0000) begin n_mis++; $display("FAIL reset_flags got=%b exp=0000", {rx_valid, frame_err, overrun_err, busy}); end
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(10);
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_idle busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    clr();
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    wait_clks(20);
    n_cmp++; if (n_acc !== 1 || last_acc !== 8'hA5) begin n_mis++; $display("FAIL basic_data got=%0d/%h exp=1/a5", n_acc, last_acc); end
    n_cmp++; if (n_vcyc !== 1) begin n_mis++; $display("FAIL basic_valid_cycles got=%0d exp=1", n_vcyc); end
    n_cmp++; if (t_valid_rise - t_busy_rise !== 761) begin n_mis++; $display("FAIL basic_latency got=%0d exp=761", t_valid_rise - t_busy_rise); end
    n_cmp++; if (t_busy_fall - t_busy_rise !== 761) begin n_mis++; $display("FAIL basic_busy_len got=%0d exp=761", t_busy_fall - t_busy_rise); end
    n_cmp++; if (n_fe !== 0 || n_oe !== 0) begin n_mis++; $display("FAIL basic_errs got=%0d/%0d exp=0/0", n_fe, n_oe); end
  endtask

  task automatic test_glitch();
    clr();
    uart_rxd = 1'b0;
    wait_clks(30);
    uart_rxd = 1'b1;
    wait_clks(100);
    n_cmp++; if (t_busy_fall - t_busy_rise !== 41) begin n_mis++; $display("FAIL glitch_busy_len got=%0d exp=41", t_busy_fall - t_busy_rise); end
    n_cmp++; if (n_vcyc !== 0 || n_fe !== 0 || n_oe !== 0) begin n_mis++; $display("FAIL glitch_flags got=%0d/%0d/%0d exp=0/0/0", n_vcyc, n_fe, n_oe); end
  endtask

  task automatic test_frame_err();
    clr();
    send_frame(8'h3C, 1'b0);
    wait_clks(2 * BIT);
    n_cmp++; if (n_fe !== 1) begin n_mis++; $display("FAIL fe_pulses got=%0d exp=1", n_fe); end
    n_cmp++; if (n_vcyc !== 0) begin n_mis++; $display("FAIL fe_valid got=%0d exp=0", n_vcyc); end
    n_cmp++; if (n_brise !== 1 || busy !== 1'b0) begin n_mis++; $display("FAIL fe_no_retrigger starts=%0d busy=%b exp=1/0", n_brise, busy); end
    uart_rxd = 1'b1;
    wait_clks(40);
    n_cmp++; if (n_brise !== 1) begin n_mis++; $display("FAIL fe_rise_no_start got=%0d exp=1", n_brise); end
  endtask

  task automatic test_overrun();
    clr();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_clks(20);
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin n_mis++; $display("FAIL ovr_hold got=%b/%h exp=1/11", rx_valid, rx_data); end
    n_cmp++; if (n_oe !== 1) begin n_mis++; $display("FAIL ovr_pulses got=%0d exp=1", n_oe); end
    rx_ready = 1'b1;
    wait_clks(10);
    n_cmp++; if (n_acc !== 1 || last_acc !== 8'h11 || rx_valid !== 1'b0) begin n_mis++; $display("FAIL ovr_drain got=%0d/%h/%b exp=1/11/0", n_acc, last_acc, rx_valid); end
  endtask

  task automatic test_simultaneous();
    int k;
    bit seen;
    clr();
    rx_ready = 1'b0;
    send_frame(8'h55, 1'b1);
    wait_clks(10);
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h55) begin n_mis++; $display("FAIL sim_pending got=%b/%h exp=1/55", rx_valid, rx_data); end
    seen = 1'b0;
    fork
      send_frame(8'h66, 1'b1);
      begin
        k = 0;
        while (!busy && k < 200) begin wait_clks(1); k++; end
        seen = busy;
        if (seen) begin
          wait_clks(760);
          rx_ready = 1'b1;
          wait_clks(1);
          rx_ready = 1'b0;
        end
      end
    join
    wait_clks(10);
    n_cmp++; if (!seen) begin n_mis++; $display("FAIL sim_start_timeout busy got=0 exp=1"); end
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h66) begin n_mis++; $display("FAIL sim_data got=%b/%h exp=1/66", rx_valid, rx_data); end
    n_cmp++; if (n_oe !== 0 || n_acc !== 1 || last_acc !== 8'h55) begin n_mis++; $display("FAIL sim_accept got=%0d/%0d/%h exp=0/1/55", n_oe, n_acc, last_acc); end
    rx_ready = 1'b1;
    wait_clks(5);
    n_cmp++; if (n_acc !== 2 || last_acc !== 8'h66) begin n_mis++; $display("FAIL sim_drain got=%0d/%h exp=2/66", n_acc, last_acc); end
  endtask

  task automatic test_abort_enable();
    logic [7:0] d;
    d = 8'hF0;
    clr();
    uart_rxd = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 3; i++) begin uart_rxd = d[i]; wait_clks(BIT); end
    uart_rxd = d[3];
    wait_clks(BIT / 2);
    n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL abort_en_busy_before got=%b exp=1", busy); end
    rx_enable = 1'b0;
    wait_clks(1);
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL abort_en_idle got=%b exp=0", busy); end
    wait_clks(BIT / 2 - 1);
    for (int i = 4; i < 8; i++) begin uart_rxd = d[i]; wait_clks(BIT); end
    uart_rxd = 1'b1;
    wait_clks(BIT);
    rx_enable = 1'b1;
    wait_clks(20);
    n_cmp++; if (n_vcyc !== 0 || n_fe !== 0 || n_oe !== 0 || busy !== 1'b0) begin n_mis++; $display("FAIL abort_en_flags got=%0d/%0d/%0d/%b exp=0/0/0/0", n_vcyc, n_fe, n_oe, busy); end
  endtask

  task automatic test_abort_reset();
    logic [7:0] d;
    d = 8'h33;
    clr();
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    wait_clks(10);
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin n_mis++; $display("FAIL rst_pending got=%b/%h exp=1/5a", rx_valid, rx_data); end
    uart_rxd = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 4; i++) begin uart_rxd = d[i]; wait_clks(BIT); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({rx_valid, frame_err, overrun_err, busy} !== 4'b0000 || rx_data !== 8'h00) begin n_mis++; $display("FAIL rst_mid_outputs got=%b/%h exp=0000/00", {rx_valid, frame_err, overrun_err, busy}, rx_data); end
    uart_rxd = 1'b1;
    wait_clks(5);
    rst_n = 1'b1;
    rx_ready = 1'b1;
    wait_clks(10);
    clr();
    send_frame(8'h81, 1'b1);
    wait_clks(20);
    n_cmp++; if (n_acc !== 1 || last_acc !== 8'h81 || n_fe !== 0 || n_oe !== 0) begin n_mis++; $display("FAIL rst_next_frame got=%0d/%h/%0d/%0d exp=1/81/0/0", n_acc, last_acc, n_fe, n_oe); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_simultaneous();
    test_abort_enable();
    test_abort_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
